// File: rtl/pixel_stream_source_if.sv
// Memory-read and pixel-stream signals between the frame reader, the pixel
// memory and the downstream line buffer.
//   master : frame reader side (drives reads and the pixel stream)
//   slave  : memory / line-buffer side (returns read data, drives ready)
interface pixel_stream_source_if #(
  parameter int unsigned DATA_SIZE  = 8,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_SIZE-1:0]  mem_data;
  logic [DATA_SIZE-1:0]  data_out;
  logic                  data_valid;
  logic                  ready;
  logic                  end_of_row;
  logic                  end_of_frame;

  modport master (
    output mem_rd_en, mem_addr, data_out, data_valid, end_of_row, end_of_frame,
    input  mem_data, ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, data_out, data_valid, end_of_row, end_of_frame,
    output mem_data, ready
  );
endinterface

// File: rtl/pixel_stream_source.sv
// Frame reader: fetches ROW_SIZE*COL_SIZE pixels from a synchronous-read
// memory starting at base_addr and streams them row-major over valid/ready,
// flagging the last pixel of each row and of the frame.
// Ports:
//   clock, reset : clock, asynchronous active-high reset
//   start        : begin one frame (sampled in IDLE only)
//   base_addr    : frame start address, latched on start
//   busy, done   : frame in progress / one-cycle completion pulse
//   bus          : memory read port and pixel stream (master side)
module pixel_stream_source #(
  parameter int unsigned DATA_SIZE  = 8,
  parameter int unsigned ROW_SIZE   = 28,
  parameter int unsigned COL_SIZE   = 28,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  pixel_stream_source_if.master bus
);

  localparam int unsigned NPIX  = ROW_SIZE * COL_SIZE;
  localparam int unsigned CNT_W = $clog2(NPIX + 1);
  localparam int unsigned COL_W = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int unsigned ROW_W = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      fetch_cnt_q, fetch_cnt_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_SIZE-1:0]  out_q, out_d;
  logic                  out_vld_q, out_vld_d;
  logic [DATA_SIZE-1:0]  skid_q, skid_d;
  logic                  skid_vld_q, skid_vld_d;
  logic                  eor_q, eor_d;
  logic                  eof_q, eof_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  xfer_c;
  logic                  out_free_c;
  logic [1:0]            held_c;
  logic                  rd_en_c;
  logic                  load_c;
  logic [DATA_SIZE-1:0]  load_data_c;

  // Next-state, datapath and read-issue logic
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    fetch_cnt_d = fetch_cnt_q;
    col_d       = col_q;
    row_d       = row_q;
    out_d       = out_q;
    out_vld_d   = out_vld_q;
    skid_d      = skid_q;
    skid_vld_d  = skid_vld_q;
    eor_d       = eor_q;
    eof_d       = eof_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    load_c      = 1'b0;
    load_data_c = skid_q;

    xfer_c     = out_vld_q & bus.ready;
    out_free_c = ~out_vld_q | bus.ready;

    // Pixels held after this edge (output + skid + word returning now).
    // A read is issued only if at most one remains, so the word it returns
    // next cycle always finds a slot even if ready then drops. The read
    // strobe depends on this cycle's ready so a stall stops fetching at once
    // and the first cycle after a stall can already refill the pipe.
    held_c  = 2'(out_vld_q) + 2'(skid_vld_q) + 2'(rvalid_q) - 2'(xfer_c);
    rd_en_c = (state_q == S_FETCH) && (held_c <= 2'd1);
    rvalid_d = rd_en_c;

    // Output register refill: skid entry first, then the returning word
    if (out_free_c) begin
      if (skid_vld_q) begin
        load_c      = 1'b1;
        load_data_c = skid_q;
        skid_vld_d  = rvalid_q;
        if (rvalid_q) skid_d = bus.mem_data;
      end else if (rvalid_q) begin
        load_c      = 1'b1;
        load_data_c = bus.mem_data;
      end else begin
        out_vld_d = 1'b0;
        eor_d     = 1'b0;
        eof_d     = 1'b0;
      end
    end else if (rvalid_q) begin
      skid_vld_d = 1'b1;
      skid_d     = bus.mem_data;
    end

    // col/row track the position of the next pixel entering the output reg
    if (load_c) begin
      out_d     = load_data_c;
      out_vld_d = 1'b1;
      eor_d     = (col_q == COL_W'(ROW_SIZE - 1));
      eof_d     = (col_q == COL_W'(ROW_SIZE - 1)) && (row_q == ROW_W'(COL_SIZE - 1));
      if (col_q == COL_W'(ROW_SIZE - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(COL_SIZE - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          fetch_cnt_d = '0;
          col_d       = '0;
          row_d       = '0;
          busy_d      = 1'b1;
          state_d     = S_FETCH;
        end
      end
      S_FETCH: begin
        if (rd_en_c) begin
          addr_d      = addr_q + ADDR_WIDTH'(1);
          fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
          if (fetch_cnt_q == CNT_W'(NPIX - 1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (xfer_c && eof_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      fetch_cnt_q <= '0;
      col_q       <= '0;
      row_q       <= '0;
      rvalid_q    <= 1'b0;
      out_q       <= '0;
      out_vld_q   <= 1'b0;
      skid_q      <= '0;
      skid_vld_q  <= 1'b0;
      eor_q       <= 1'b0;
      eof_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      fetch_cnt_q <= fetch_cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      rvalid_q    <= rvalid_d;
      out_q       <= out_d;
      out_vld_q   <= out_vld_d;
      skid_q      <= skid_d;
      skid_vld_q  <= skid_vld_d;
      eor_q       <= eor_d;
      eof_q       <= eof_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.mem_rd_en    = rd_en_c;
  assign bus.mem_addr     = addr_q;
  assign bus.data_out     = out_q;
  assign bus.data_valid   = out_vld_q;
  assign bus.end_of_row   = eor_q;
  assign bus.end_of_frame = eof_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_pixel_stream_source.sv
// Bench for pixel_stream_source on a 4x3 frame with a 1024-word memory model.
module tb_pixel_stream_source;
  localparam int unsigned DW = 8;
  localparam int unsigned RS = 4;
  localparam int unsigned CS = 3;
  localparam int unsigned AW = 10;
  localparam int unsigned NP = RS * CS;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          busy;
  logic          done;

  pixel_stream_source_if #(.DATA_SIZE(DW), .ADDR_WIDTH(AW)) ifc ();

  pixel_stream_source #(.DATA_SIZE(DW), .ROW_SIZE(RS), .COL_SIZE(CS), .ADDR_WIDTH(AW)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .base_addr(base_addr),
    .busy     (busy),
    .done     (done),
    .bus      (ifc.master)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clock) if (ifc.mem_rd_en) ifc.mem_data <= mem[ifc.mem_addr];

  typedef struct {
    logic [DW-1:0] data;
    logic          eor;
    logic          eof;
  } pix_t;

  typedef struct {
    logic [AW-1:0] base;
    int            mode;        // 0 ready=1, 1 stall fc5..9, 2 random, 3 toggle, 4 start re-pulse
    int            exp_done_fc; // -1: timing not checked
  } vec_t;

  pix_t          exp_q[$];
  vec_t          vecs[7];
  int            errors = 0;
  int            checks = 0;
  int            fc, mode, xfers, reads, done_cnt, done_fc, max_out;
  logic [AW-1:0] exp_addr, cur_base;
  logic          stall_prev, stall_eor, stall_eof;
  logic [DW-1:0] stall_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_en"}, 32'(ifc.mem_rd_en), 0);
    check({tag, "_addr"},  32'(ifc.mem_addr), 0);
    check({tag, "_data"},  32'(ifc.data_out), 0);
    check({tag, "_valid"}, 32'(ifc.data_valid), 0);
    check({tag, "_eor"},   32'(ifc.end_of_row), 0);
    check({tag, "_eof"},   32'(ifc.end_of_frame), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
  endtask

  // Negedge sampling: address order, scoreboard pops, hold rule, done pulse
  task automatic monitor();
    pix_t p;
    bit   timed;
    timed = (mode == 0) || (mode == 4) || (mode == 5);
    if (ifc.mem_rd_en) begin
      check("mem_addr", 32'(ifc.mem_addr), 32'(exp_addr));
      exp_addr = exp_addr + AW'(1);
      reads++;
    end
    if (stall_prev) begin
      check("hold_valid", 32'(ifc.data_valid), 1);
      check("hold_data", 32'(ifc.data_out), 32'(stall_data));
      check("hold_eor", 32'(ifc.end_of_row), 32'(stall_eor));
      check("hold_eof", 32'(ifc.end_of_frame), 32'(stall_eof));
    end
    if (timed && (fc == 0 || fc == 1)) check("early_valid", 32'(ifc.data_valid), 0);
    if (ifc.data_valid && ifc.ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL extra_pixel: got data %0d with no pixel expected", ifc.data_out);
      end else begin
        p = exp_q.pop_front();
        if (ifc.data_out !== p.data || ifc.end_of_row !== p.eor || ifc.end_of_frame !== p.eof) begin
          errors++;
          $display("FAIL pixel%0d: got data=%0d eor=%0b eof=%0b expected data=%0d eor=%0b eof=%0b",
                   xfers, ifc.data_out, ifc.end_of_row, ifc.end_of_frame, p.data, p.eor, p.eof);
        end
        if (timed) check("xfer_cycle", 32'(fc), 32'(2 + xfers));
      end
      xfers++;
    end
    if (mode == 1 && fc >= 6 && fc <= 9) check("rd_stop", 32'(ifc.mem_rd_en), 0);
    if (done) begin
      done_cnt++;
      done_fc = fc;
      check("done_busy", 32'(busy), 0);
    end
    if (reads - xfers > max_out) max_out = reads - xfers;
    stall_prev = ifc.data_valid && !ifc.ready;
    stall_data = ifc.data_out;
    stall_eor  = ifc.end_of_row;
    stall_eof  = ifc.end_of_frame;
  endtask

  task automatic cycle();
    @(negedge clock);
    monitor();
    @(posedge clock);
    #1;
    fc++;
    case (mode)
      1:       ifc.ready = !(fc >= 5 && fc <= 9);
      2:       ifc.ready = 1'($urandom_range(0, 1));
      3:       ifc.ready = ~ifc.ready;
      default: ifc.ready = 1'b1;
    endcase
    if (mode == 4) begin
      if (fc == 5) begin
        start = 1'b1;
        base_addr = AW'(100);
      end else if (fc == 6) begin
        start = 1'b0;
        base_addr = cur_base;
      end
    end
  endtask

  // Expected pixels for one frame are queued as the start is driven
  task automatic arm(input logic [AW-1:0] b, input int m);
    pix_t p;
    logic [AW-1:0] a;
    cur_base = b;
    base_addr = b;
    exp_addr = b;
    exp_q.delete();
    for (int k = 0; k < int'(NP); k++) begin
      a = b + AW'(k);
      p.data = mem[a];
      p.eor  = ((k % int'(RS)) == int'(RS) - 1);
      p.eof  = (k == int'(NP) - 1);
      exp_q.push_back(p);
    end
    reads = 0; xfers = 0; done_cnt = 0; done_fc = -1; max_out = 0;
    mode = m;
    stall_prev = 1'b0;
    ifc.ready = 1'b1;
    fc = -1;
  endtask

  task automatic finish_frame(input int exp_done_fc, input bit extra);
    for (int i = 0; i < 400 && done_cnt == 0; i++) cycle();
    check("done_seen", 32'(done_cnt), 1);
    check("xfer_count", 32'(xfers), NP);
    check("read_count", 32'(reads), NP);
    check("leftover", 32'(exp_q.size()), 0);
    checks++;
    if (max_out > 2) begin
      errors++;
      $display("FAIL outstanding: got %0d pixels outstanding, at most 2 allowed", max_out);
    end
    if (exp_done_fc >= 0) check("done_cycle", 32'(done_fc), 32'(exp_done_fc));
    if (extra) begin
      cycle();
      cycle();
      check("done_width", 32'(done_cnt), 1);
      check("idle_valid", 32'(ifc.data_valid), 0);
      check("idle_busy", 32'(busy), 0);
    end
  endtask

  task automatic run_frame(input vec_t v);
    arm(v.base, v.mode);
    start = 1'b1;
    cycle();
    if (v.mode != 5) start = 1'b0;
    finish_frame(v.exp_done_fc, v.mode != 5);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t hv;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i + 16);
    vecs[0] = '{AW'(0),    0, 14};
    vecs[1] = '{AW'(0),    1, 19};
    vecs[2] = '{AW'(0),    2, -1};
    vecs[3] = '{AW'(1020), 0, 14};
    vecs[4] = '{AW'(1020), 3, -1};
    vecs[5] = '{AW'(0),    4, 14};
    vecs[6] = '{AW'(7),    2, -1};

    reset = 1'b0; start = 1'b0; base_addr = '0; ifc.ready = 1'b0; mode = 0; fc = -1;
    stall_prev = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_outputs_zero("reset");
    reset = 1'b0;
    @(posedge clock);
    #1;

    for (int v = 0; v < 7; v++) run_frame(vecs[v]);

    // start held high through done: next frame accepted the cycle after DONE
    hv = '{AW'(0), 5, 14};
    run_frame(hv);
    check("gap_busy", 32'(busy), 0);
    check("gap_done", 32'(done), 0);
    check("gap_rd_en", 32'(ifc.mem_rd_en), 0);
    arm(AW'(0), 0);
    cycle();
    start = 1'b0;
    check("restart_busy", 32'(busy), 1);
    check("restart_rd_en", 32'(ifc.mem_rd_en), 1);
    finish_frame(14, 1'b1);

    // asynchronous reset after the 5th pixel, then a clean replay
    arm(AW'(0), 0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 50 && xfers < 5; i++) cycle();
    check("pre_reset_xfers", 32'(xfers), 5);
    #2 reset = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    exp_q.delete();
    stall_prev = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    run_frame(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
